pet2001_vram_uart: RTL and testbench

- Snoops CPU writes to PET video RAM and converts each written screen code to ASCII.
- Buffers the ASCII bytes in a small FIFO and feeds them to the transmit side of the existing uart block (write_data/write_strobe/write_rdy).
- A host terminal therefore sees screen output. This is the reverse path of the UART-to-keystroke path.
- Sits in the board top level between pet2001_top's video-RAM write port and uart0.

---
 rtl/pet2001_vram_uart.sv | 192 +++++++++++++++++++
 tb/tb_pet2001_vram_uart.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pet2001_vram_uart.sv
// pet2001_vram_uart: snoops CPU writes into PET video RAM, converts each
// screen code to ASCII, inserts CR LF whenever the write address is not
// contiguous with the previous one, buffers the bytes in a small FIFO and
// feeds them to the uart transmit handshake (write_data/write_strobe/write_rdy).
module pet2001_vram_uart #(
  parameter int         FIFO_AW    = 4,
  parameter logic [7:0] SUBST_CHAR = 8'h2E
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       vram_we,
  input  logic [9:0] vram_addr,
  input  logic [7:0] vram_data,
  input  logic       uart_rdy,
  output logic [7:0] uart_data,
  output logic       uart_strobe,
  output logic       overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0] PTR_ZERO = {(FIFO_AW + 1){1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CR   = 2'd1,
    ST_LF   = 2'd2,
    ST_CHR  = 2'd3
  } state_t;

  // Screen code to ASCII. Bit 7 (reverse video) is ignored; the upper half of
  // the 7-bit code space holds PET graphics, which have no ASCII equivalent.
  function automatic logic [7:0] screen_to_ascii(input logic [7:0] code);
    logic [6:0] c;
    logic [7:0] r;
    c = code[6:0];
    if (c == 7'h00) begin
      r = 8'h40;
    end else if (c < 7'h20) begin
      r = {1'b0, c} + 8'h40;
    end else if (c < 7'h40) begin
      r = {1'b0, c};
    end else begin
      r = SUBST_CHAR;
    end
    return r;
  endfunction

  // Sequencer and framing state
  state_t      state_q, state_d;
  logic [7:0]  char_q, char_d;
  logic [9:0]  exp_addr_q, exp_addr_d;
  logic        exp_valid_q, exp_valid_d;

  // FIFO state (extra pointer bit separates full from empty)
  logic [7:0]       mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;

  // Output registers
  logic [7:0] uart_data_q, uart_data_d;
  logic       uart_strobe_q, uart_strobe_d;
  logic       overflow_q, overflow_d;

  // Internal combinational signals
  logic       wr_req_s;
  logic       busy_drop_s;
  logic       push_s;
  logic [7:0] push_data_s;
  logic       empty_s;
  logic       full_s;
  logic       pop_s;
  logic       push_ok_s;
  logic       push_drop_s;

  assign wr_req_s    = vram_we & en;
  assign busy_drop_s = wr_req_s & (state_q != ST_IDLE);

  // Sequencer: accept a write in IDLE, then emit CR, LF (if framing) and the char
  always_comb begin
    state_d     = state_q;
    char_d      = char_q;
    exp_addr_d  = exp_addr_q;
    exp_valid_d = exp_valid_q;
    push_s      = 1'b0;
    push_data_s = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (wr_req_s) begin
          char_d      = screen_to_ascii(vram_data);
          exp_addr_d  = vram_addr + 10'd1;
          exp_valid_d = 1'b1;
          if (exp_valid_q && (vram_addr != exp_addr_q)) begin
            state_d = ST_CR;
          end else begin
            state_d = ST_CHR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CR: begin
        push_s      = 1'b1;
        push_data_s = 8'h0D;
        state_d     = ST_LF;
      end
      ST_LF: begin
        push_s      = 1'b1;
        push_data_s = 8'h0A;
        state_d     = ST_CHR;
      end
      ST_CHR: begin
        push_s      = 1'b1;
        push_data_s = char_q;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  // Never strobe two cycles in a row: the uart only lowers rdy after a strobe.
  assign pop_s       = ~empty_s & uart_rdy & ~uart_strobe_q;
  // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
  assign push_ok_s   = push_s & (~full_s | pop_s);
  assign push_drop_s = push_s & ~push_ok_s;

  // FIFO pointers, transmit registers and sticky overflow
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    uart_data_d   = uart_data_q;
    uart_strobe_d = 1'b0;
    overflow_d    = overflow_q | busy_drop_s | push_drop_s;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d      = rd_ptr_q + PTR_ONE;
      uart_data_d   = mem_q[rd_ptr_q[FIFO_AW-1:0]];
      uart_strobe_d = 1'b1;
    end else begin
      rd_ptr_d      = rd_ptr_q;
      uart_data_d   = uart_data_q;
      uart_strobe_d = 1'b0;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_data_s;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      char_q        <= 8'h00;
      exp_addr_q    <= 10'h000;
      exp_valid_q   <= 1'b0;
      wr_ptr_q      <= PTR_ZERO;
      rd_ptr_q      <= PTR_ZERO;
      uart_data_q   <= 8'h00;
      uart_strobe_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      char_q        <= char_d;
      exp_addr_q    <= exp_addr_d;
      exp_valid_q   <= exp_valid_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      uart_data_q   <= uart_data_d;
      uart_strobe_q <= uart_strobe_d;
      overflow_q    <= overflow_d;
    end
  end

  assign uart_data   = uart_data_q;
  assign uart_strobe = uart_strobe_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_pet2001_vram_uart.sv
// Self-checking bench for pet2001_vram_uart: a behavioural model turns each
// accepted vram write into the expected ASCII byte stream, and a monitor
// collects every strobed byte for comparison.
module tb_pet2001_vram_uart;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic       vram_we = 1'b0;
  logic [9:0] vram_addr = 10'h000;
  logic [7:0] vram_data = 8'h00;
  logic       uart_rdy = 1'b1;
  logic [7:0] uart_data;
  logic       uart_strobe;
  logic       overflow;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  logic [9:0] m_exp_addr;
  bit         m_exp_valid;
  logic [7:0] exp_q [$];
  logic [7:0] obs_q [$];
  bit         prev_strobe = 1'b0;
  bit         b2b_seen = 1'b0;

  pet2001_vram_uart #(.FIFO_AW(4), .SUBST_CHAR(8'h2E)) dut (
    .clk(clk), .reset(reset), .en(en), .vram_we(vram_we),
    .vram_addr(vram_addr), .vram_data(vram_data), .uart_rdy(uart_rdy),
    .uart_data(uart_data), .uart_strobe(uart_strobe), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Monitor: collect transmitted bytes, note any consecutive strobes
  always @(negedge clk) begin
    if (uart_strobe) obs_q.push_back(uart_data);
    if (uart_strobe && prev_strobe) b2b_seen = 1'b1;
    prev_strobe = uart_strobe;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] ref_conv(input logic [7:0] sc);
    int v;
    v = int'(sc) % 128;
    if (v < 32) return 8'(v + 64);
    if (v < 64) return 8'(v);
    return 8'h2E;
  endfunction

  // Model of an accepted write: optional CR LF, then the character
  task automatic model_accept(input logic [9:0] a, input logic [7:0] d);
    if (m_exp_valid && a != m_exp_addr) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    exp_q.push_back(ref_conv(d));
    m_exp_addr  = a + 10'd1;
    m_exp_valid = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_exp_valid = 1'b0;
    m_exp_addr  = 10'h000;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic do_write(input logic [9:0] a, input logic [7:0] d, input int gap);
    @(negedge clk);
    vram_we = 1'b1; vram_addr = a; vram_data = d;
    @(negedge clk);
    vram_we = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Wait (bounded) until the monitor has as many bytes as the model expects
  task automatic wait_drain();
    int waited = 0;
    while (obs_q.size() < exp_q.size() && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_exp_valid = 1'b0;
    m_exp_addr = 10'h000;
    @(negedge clk);
    n_cmp++; if (uart_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", uart_data); end
    n_cmp++; if (uart_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b want 0", uart_strobe); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_first_write();
    do_write(10'h000, 8'h08, 3); model_accept(10'h000, 8'h08);
    wait_drain();
    n_cmp++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL first_count: got %0d want 1", obs_q.size()); end
    n_cmp++; if (obs_q.size() < 1 || obs_q[0] !== 8'h48) begin n_fail++; $display("FAIL first_byte: got %h want 48", (obs_q.size() > 0) ? obs_q[0] : 8'hxx); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL first_overflow: got %b want 0", overflow); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_framing();
    do_write(10'h001, 8'h05, 3); model_accept(10'h001, 8'h05);
    do_write(10'h002, 8'h0C, 3); model_accept(10'h002, 8'h0C);
    do_write(10'h028, 8'h21, 3); model_accept(10'h028, 8'h21);
    wait_drain();
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL framing_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL framing_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_conversion();
    logic [7:0] codes [5];
    logic [7:0] last;
    codes = '{8'h00, 8'h81, 8'h20, 8'h5A, 8'hE0};
    for (int i = 0; i < 5; i++) begin
      do_write(m_exp_addr, codes[i], 3);
      model_accept(m_exp_addr, codes[i]);
    end
    wait_drain();
    last = exp_q[exp_q.size() - 1];
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL conv_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL conv_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (uart_data !== last) begin n_fail++; $display("FAIL conv_hold: got %h want %h", uart_data, last); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_fifo_full();
    logic [7:0] d;
    uart_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom_range(0, 255));
      do_write(m_exp_addr, d, 3);
      model_accept(m_exp_addr, d);
    end
    while (exp_q.size() > 16) void'(exp_q.pop_back());
    repeat (5) @(negedge clk);
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_overflow: got %b want 1", overflow); end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL full_no_tx: got %0d want 0", obs_q.size()); end
    uart_rdy = 1'b1;
    wait_drain();
    n_cmp++; if (obs_q.size() != 16) begin n_fail++; $display("FAIL full_count: got %0d want 16", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_busy_drop();
    do_reset();
    do_write(10'h100, 8'h01, 3); model_accept(10'h100, 8'h01);
    @(negedge clk);
    vram_we = 1'b1; vram_addr = 10'h200; vram_data = 8'h02;
    @(negedge clk);
    vram_addr = 10'h201; vram_data = 8'h03;
    @(negedge clk);
    vram_we = 1'b0;
    model_accept(10'h200, 8'h02);
    wait_drain();
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL busy_overflow: got %b want 1", overflow); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL busy_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL busy_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
    do_write(10'h201, 8'h04, 3); model_accept(10'h201, 8'h04);
    wait_drain();
    n_cmp++; if (obs_q.size() != 1 || obs_q[0] !== 8'h44) begin n_fail++; $display("FAIL busy_expaddr: got %0d bytes first %h want 1 byte 44", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'hxx); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midway();
    logic [9:0] a;
    do_reset();
    uart_rdy = 1'b0;
    for (int i = 0; i < 5; i++) do_write(10'(i), 8'(i + 1), 3);
    @(negedge clk);
    vram_we = 1'b1; vram_addr = 10'h300; vram_data = 8'h10;
    @(negedge clk);
    vram_we = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    uart_rdy = 1'b1;
    reset = 1'b0;
    m_exp_valid = 1'b0;
    exp_q.delete();
    obs_q.delete();
    repeat (30) @(negedge clk);
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL midreset_no_tx: got %0d want 0", obs_q.size()); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midreset_overflow: got %b want 0", overflow); end
    a = 10'($urandom_range(0, 1023));
    do_write(a, 8'h13, 3); model_accept(a, 8'h13);
    wait_drain();
    n_cmp++; if (obs_q.size() != 1 || obs_q[0] !== 8'h53) begin n_fail++; $display("FAIL midreset_first: got %0d bytes first %h want 1 byte 53", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'hxx); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_en();
    logic [9:0] a;
    a = m_exp_addr + 10'd100;
    en = 1'b0;
    do_write(a, 8'h01, 5);
    repeat (10) @(negedge clk);
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL en_ignored: got %0d bytes want 0", obs_q.size()); end
    en = 1'b1;
    uart_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_write(m_exp_addr, 8'(8'h30 + i), 3);
      model_accept(m_exp_addr, 8'(8'h30 + i));
    end
    en = 1'b0;
    uart_rdy = 1'b1;
    wait_drain();
    en = 1'b1;
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL en_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL en_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_wrap();
    do_write(10'h3FF, 8'h01, 7); model_accept(10'h3FF, 8'h01);
    do_write(10'h000, 8'h02, 7); model_accept(10'h000, 8'h02);
    wait_drain();
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [9:0] a;
    logic [7:0] d;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 9) < 7) ? m_exp_addr : 10'($urandom_range(0, 1023));
      d = 8'($urandom_range(0, 255));
      do_write(a, d, 7);
      model_accept(a, d);
    end
    wait_drain();
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rand_overflow: got %b want 0", overflow); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    uart_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 63));
      do_write(m_exp_addr, d, 2);
      model_accept(m_exp_addr, d);
    end
    uart_rdy = 1'b1;
    wait_drain();
    n_cmp++; if (b2b_seen !== 1'b0) begin n_fail++; $display("FAIL b2b_spacing: consecutive strobes got %b want 0", b2b_seen); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_first_write();
    test_framing();
    test_conversion();
    test_wrap();
    test_random();
    test_back_to_back();
    test_en();
    test_fifo_full();
    test_busy_drop();
    test_reset_midway();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
